// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//
// Sequencing controller for a 2-way set-associative byte cache
// (2**IW sets x 2 ways, 2-byte lines). This block owns the tag, valid and LRU
// state and steers an external data array. That array reads combinationally
// and writes one byte on a clock edge.
//
// Policy:
//   - One CPU request is in flight at a time.
//   - A read miss fills both bytes of the line from memory.
//   - Writes go straight through to memory.
//   - A write miss does not allocate a line.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   cpu_*        CPU side. cpu_req is held until the cpu_done pulse. cpu_rdata
//                and cpu_hit are valid while cpu_done is high.
//   mem_*        memory side. mem_req is held until the one-cycle mem_ack.
//   da_*         external data-array way/set/byte select, write byte, write
//                enable, and combinational read byte
//   hit_cnt,
//   miss_cnt     saturating hit/miss statistics
// ---------------------------------------------------------------------------
module cache_ctrl #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int IW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  // CPU interface
  input  logic          cpu_req,
  input  logic          cpu_rw_,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_hit,
  // memory interface
  output logic          mem_req,
  output logic          mem_rw_,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  // external data array
  output logic          da_way,
  output logic [IW-1:0] da_index,
  output logic          da_word,
  output logic [DW-1:0] da_wdata,
  output logic          da_we,
  input  logic [DW-1:0] da_rdata,
  // statistics
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] miss_cnt
);

  localparam int TW   = AW - IW - 1;
  localparam int SETS = 1 << IW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_FILL0  = 3'd2;
  localparam logic [2:0] S_FILL1  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]            r_state;
  logic [AW-1:0]         r_addr;
  logic                  r_rw;
  logic [DW-1:0]         r_wdata;
  logic                  r_hit;      // lookup result, reported after MEMWR
  logic                  r_victim;   // way chosen for the current fill
  logic                  r_mem_req;
  logic [DW-1:0]         r_cpu_rdata;
  logic                  r_cpu_hit;
  logic [CW-1:0]         r_hit_cnt;
  logic [CW-1:0]         r_miss_cnt;
  logic [1:0][SETS-1:0]  r_valid;
  logic [SETS-1:0]       r_lru;      // way to evict next when both are valid
  logic [TW-1:0]         r_tag [0:1][0:SETS-1];

  // -------------------------------------------------------------------------
  // Address decomposition of the latched request
  // -------------------------------------------------------------------------
  logic [IW-1:0] w_idx;
  logic          w_word;
  logic [TW-1:0] w_tag;

  assign w_idx  = r_addr[IW:1];
  assign w_word = r_addr[0];
  assign w_tag  = r_addr[AW-1:IW+1];

  // Per-way tag compare
  logic [1:0] w_hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way_cmp
      assign w_hit[gi] = r_valid[gi][w_idx] & (r_tag[gi][w_idx] == w_tag);
    end
  endgenerate

  logic w_any_hit;
  logic w_hit_way;

  assign w_any_hit = |w_hit;
  assign w_hit_way = w_hit[1];  // both ways never hit together

  // Victim selection: prefer an empty way, otherwise follow LRU
  logic w_victim;

  always_comb begin
    w_victim = r_lru[w_idx];
    if (!r_valid[0][w_idx]) begin
      w_victim = 1'b0;
    end else if (!r_valid[1][w_idx]) begin
      w_victim = 1'b1;
    end
  end

  // An ack only counts while we are actually requesting, so stray acks in
  // other states, and in the gap cycle between the two fill beats, are
  // ignored.
  logic w_ack;

  assign w_ack = r_mem_req & mem_ack;

  // -------------------------------------------------------------------------
  // Main sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_victim    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_hit   <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_valid     <= '0;
      r_lru       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_rw    <= cpu_rw_;
            r_wdata <= cpu_wdata;
            r_state <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          r_hit    <= w_any_hit;
          r_victim <= w_victim;
          if (w_any_hit) begin
            r_lru[w_idx] <= ~w_hit_way;
            if (r_hit_cnt != {CW{1'b1}}) begin
              r_hit_cnt <= r_hit_cnt + 1'b1;
            end
          end else if (r_miss_cnt != {CW{1'b1}}) begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
          end

          if (r_rw) begin
            if (w_any_hit) begin
              // da_way already points at the hit way this cycle
              r_cpu_rdata <= da_rdata;
              r_cpu_hit   <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_mem_req <= 1'b1;
              r_state   <= S_FILL0;
            end
          end else begin
            r_mem_req <= 1'b1;
            r_state   <= S_MEMWR;
          end
        end

        S_FILL0: begin
          if (w_ack) begin
            if (!w_word) begin
              r_cpu_rdata <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_state   <= S_FILL1;
          end
        end

        S_FILL1: begin
          if (!r_mem_req) begin
            // Request drops for one cycle after the first beat's ack
            r_mem_req <= 1'b1;
          end else if (mem_ack) begin
            if (w_word) begin
              r_cpu_rdata <= mem_rdata;
            end
            r_mem_req                <= 1'b0;
            r_valid[r_victim][w_idx] <= 1'b1;
            r_lru[w_idx]             <= ~r_victim;
            r_cpu_hit                <= 1'b0;
            r_state                  <= S_DONE;
          end
        end

        S_MEMWR: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_cpu_hit <= r_hit;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tags are never reset. Validity alone decides whether a tag means
  // anything. The tag is written only on the final beat of a fill, so a fill
  // cut short by reset leaves the stored tag untouched.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_FILL1) && w_ack) begin
      r_tag[r_victim][w_idx] <= w_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_hit   = r_cpu_hit;
  assign cpu_done  = (r_state == S_DONE);
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  assign mem_req   = r_mem_req;
  assign mem_rw_   = (r_state != S_MEMWR);
  assign mem_wdata = r_wdata;
  assign mem_addr  = (r_state == S_MEMWR) ? r_addr
                                          : {w_tag, w_idx, (r_state == S_FILL1)};

  // Data-array steering:
  //   - LOOKUP addresses the hit way. This serves both the read-hit data and
  //     the write-hit byte update.
  //   - Fills write the victim way, one beat per ack.
  always_comb begin
    da_way   = 1'b0;
    da_index = w_idx;
    da_word  = w_word;
    da_wdata = mem_rdata;
    da_we    = 1'b0;
    case (r_state)
      S_LOOKUP: begin
        da_way   = w_hit_way;
        da_wdata = r_wdata;
        da_we    = ~r_rw & w_any_hit;
      end
      S_FILL0: begin
        da_way  = r_victim;
        da_word = 1'b0;
        da_we   = w_ack;
      end
      S_FILL1: begin
        da_way  = r_victim;
        da_word = 1'b1;
        da_we   = w_ack;
      end
      default: begin
        da_way = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
//
// Self-checking bench for cache_ctrl. Models the external data array and main
// memory. Expected CPU completions, memory operations and data-array writes
// are queued by the stimulus and consumed by independent monitors.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_rw_;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  logic          cpu_hit;
  logic          mem_req;
  logic          mem_rw_;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          da_way;
  logic [IW-1:0] da_index;
  logic          da_word;
  logic [DW-1:0] da_wdata;
  logic          da_we;
  logic [DW-1:0] da_rdata;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  cache_ctrl #(.AW(AW), .DW(DW), .IW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_rw_   (cpu_rw_),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_rw_   (mem_rw_),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .da_way    (da_way),
    .da_index  (da_index),
    .da_word   (da_word),
    .da_wdata  (da_wdata),
    .da_we     (da_we),
    .da_rdata  (da_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    logic       rw;
    logic [7:0] rdata;
    logic       hit;
  } cpu_exp_t;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  typedef struct {
    logic       way;
    logic [3:0] idx;
    logic       word;
    logic [7:0] data;
  } da_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  da_exp_t  da_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
    mem_exp_t e;
    e.rw    = rw;
    e.addr  = addr;
    e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  task automatic exp_da(input logic way, input logic [3:0] idx, input logic word,
                        input logic [7:0] data);
    da_exp_t e;
    e.way  = way;
    e.idx  = idx;
    e.word = word;
    e.data = data;
    da_q.push_back(e);
  endtask

  // -------------------------------------------------------------------------
  // External data array model: combinational read, write on the clock edge
  // -------------------------------------------------------------------------
  logic [7:0] da_mem [0:1][0:15][0:1];

  assign da_rdata = da_mem[da_way][da_index][da_word];

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 16; s++) begin
        for (int b = 0; b < 2; b++) begin
          da_mem[w][s][b] = 8'h00;
        end
      end
    end
    forever begin
      @(posedge clk);
      if (da_we === 1'b1) begin
        da_mem[da_way][da_index][da_word] = da_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Main memory model and responder (drives 2 time units after the edge)
  // -------------------------------------------------------------------------
  logic [7:0] mem_arr [0:65535];

  int mem_lat      = 0;
  int acks_allowed = -1;  // -1 = unlimited
  int ack_total    = 0;
  int lat_cnt      = 0;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem_arr[a] = 8'h00;
    end
    mem_arr[16'h1234] = 8'hA0;
    mem_arr[16'h1235] = 8'hA1;
    mem_arr[16'h3234] = 8'hB0;
    mem_arr[16'h3235] = 8'hB1;
    mem_arr[16'h5234] = 8'hC0;
    mem_arr[16'h5235] = 8'hC1;
    mem_arr[16'h2468] = 8'hD0;
    mem_arr[16'h2469] = 8'hD1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req === 1'b1 && acks_allowed != 0) begin
        if (lat_cnt >= mem_lat) begin
          lat_cnt = 0;
          mem_ack = 1'b1;
          ack_total++;
          if (acks_allowed > 0) begin
            acks_allowed--;
          end
          if (mem_rw_) begin
            mem_rdata = mem_arr[mem_addr];
          end else begin
            mem_arr[mem_addr] = mem_wdata;
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitors
  // -------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_done === 1'b1) begin
        if (cpu_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cpu_unexpected: got cpu_done with rdata=%h hit=%0d, required no completion",
                   cpu_rdata, cpu_hit);
        end else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          check("cpu_hit", {31'd0, cpu_hit}, {31'd0, e.hit});
          if (e.rw) begin
            check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.rdata});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        if (mem_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_unexpected: got rw=%0d addr=%h, required no memory op",
                   mem_rw_, mem_addr);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_op", {15'd0, mem_rw_, mem_addr}, {15'd0, e.rw, e.addr});
          if (!e.rw) begin
            check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (da_we === 1'b1) begin
        if (da_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL da_unexpected: got way=%0d idx=%h word=%0d data=%h, required no write",
                   da_way, da_index, da_word, da_wdata);
        end else begin
          da_exp_t e;
          e = da_q.pop_front();
          check("da_write", {18'd0, da_way, da_index, da_word, da_wdata},
                            {18'd0, e.way, e.idx, e.word, e.data});
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  // exp_lat > 0: number of cycles from the request-sample edge to the cycle
  // in which cpu_done is seen.
  task automatic do_req(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                        input logic exp_hit, input logic [7:0] exp_rdata, input int exp_lat);
    cpu_exp_t e;
    int       n;
    bit       got;
    e.rw    = rw;
    e.rdata = exp_rdata;
    e.hit   = exp_hit;
    cpu_q.push_back(e);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rw_   = rw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (cpu_done === 1'b1) begin
        got = 1'b1;
      end
    end
    cpu_req = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL cpu_timeout: got no cpu_done after %0d cycles, required completion", n);
    end else if (exp_lat > 0) begin
      check("latency", n, exp_lat);
    end
    $display("[TB] %s addr=%h wdata=%h -> rdata=%h hit=%0d cycles=%0d hit_cnt=%0d miss_cnt=%0d",
             rw ? "RD" : "WR", addr, wdata, cpu_rdata, cpu_hit, n, hit_cnt, miss_cnt);
  endtask

  initial begin
    int n;
    int base;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_rw_   = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_cpu_done", {31'd0, cpu_done}, 32'd0);
    check("rst_mem_req",  {31'd0, mem_req},  32'd0);
    check("rst_da_we",    {31'd0, da_we},    32'd0);
    check("rst_rdata",    {24'd0, cpu_rdata}, 32'd0);
    check("rst_cpu_hit",  {31'd0, cpu_hit},  32'd0);
    check("rst_hit_cnt",  {16'd0, hit_cnt},  32'd0);
    check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    rst = 1'b0;

    // Cold read miss: two-beat fill into way 0 of set A
    exp_mem(1'b1, 16'h1234, 8'h00);
    exp_mem(1'b1, 16'h1235, 8'h00);
    exp_da(1'b0, 4'hA, 1'b0, 8'hA0);
    exp_da(1'b0, 4'hA, 1'b1, 8'hA1);
    do_req(1'b1, 16'h1234, 8'h00, 1'b0, 8'hA0, 0);
    check("miss_cnt_1", {16'd0, miss_cnt}, 32'd1);

    // Read hit on the other byte of that line: 2-cycle latency
    do_req(1'b1, 16'h1235, 8'h00, 1'b1, 8'hA1, 2);
    check("hit_cnt_1", {16'd0, hit_cnt}, 32'd1);

    // Same set, different tag: empty way 1 is the victim (slow memory)
    mem_lat = 2;
    exp_mem(1'b1, 16'h3234, 8'h00);
    exp_mem(1'b1, 16'h3235, 8'h00);
    exp_da(1'b1, 4'hA, 1'b0, 8'hB0);
    exp_da(1'b1, 4'hA, 1'b1, 8'hB1);
    do_req(1'b1, 16'h3234, 8'h00, 1'b0, 8'hB0, 0);
    mem_lat = 0;

    // Re-read 0x1234 hits way 0 and makes way 1 the LRU
    do_req(1'b1, 16'h1234, 8'h00, 1'b1, 8'hA0, 2);

    // 0x5234: both ways valid, so LRU way 1 is evicted
    exp_mem(1'b1, 16'h5234, 8'h00);
    exp_mem(1'b1, 16'h5235, 8'h00);
    exp_da(1'b1, 4'hA, 1'b0, 8'hC0);
    exp_da(1'b1, 4'hA, 1'b1, 8'hC1);
    do_req(1'b1, 16'h5234, 8'h00, 1'b0, 8'hC0, 0);

    // 0x1234 survived the eviction
    do_req(1'b1, 16'h1234, 8'h00, 1'b1, 8'hA0, 2);

    // 0x3234 was evicted: it misses and replaces way 1 again
    exp_mem(1'b1, 16'h3234, 8'h00);
    exp_mem(1'b1, 16'h3235, 8'h00);
    exp_da(1'b1, 4'hA, 1'b0, 8'hB0);
    exp_da(1'b1, 4'hA, 1'b1, 8'hB1);
    do_req(1'b1, 16'h3234, 8'h00, 1'b0, 8'hB0, 0);

    // Write hit: array byte updated in way 0, then a write-through
    exp_da(1'b0, 4'hA, 1'b1, 8'h55);
    exp_mem(1'b0, 16'h1235, 8'h55);
    do_req(1'b0, 16'h1235, 8'h55, 1'b1, 8'h00, 0);
    do_req(1'b1, 16'h1235, 8'h00, 1'b1, 8'h55, 2);

    // Write miss: memory write only, no allocation
    exp_mem(1'b0, 16'h7000, 8'h77);
    do_req(1'b0, 16'h7000, 8'h77, 1'b0, 8'h00, 0);
    exp_mem(1'b1, 16'h7000, 8'h00);
    exp_mem(1'b1, 16'h7001, 8'h00);
    exp_da(1'b0, 4'h0, 1'b0, 8'h77);
    exp_da(1'b0, 4'h0, 1'b1, 8'h00);
    do_req(1'b1, 16'h7000, 8'h00, 1'b0, 8'h77, 0);
    check("hit_cnt_5",  {16'd0, hit_cnt},  32'd5);
    check("miss_cnt_6", {16'd0, miss_cnt}, 32'd6);

    // Reset while the second fill beat is outstanding
    exp_mem(1'b1, 16'h2468, 8'h00);
    exp_da(1'b0, 4'h4, 1'b0, 8'hD0);
    acks_allowed = 1;
    base         = ack_total;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rw_   = 1'b1;
    cpu_addr  = 16'h2468;
    cpu_wdata = 8'h00;
    n = 0;
    while (n < 100 && !(ack_total == base + 1 && mem_req === 1'b1 && mem_ack === 1'b0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL fill1_timeout: got no second fill request after %0d cycles, required one", n);
    end else begin
      check("fill1_addr", {16'd0, mem_addr}, 32'h2469);
    end
    cpu_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_mem_req",  {31'd0, mem_req},  32'd0);
    check("rstmid_cpu_done", {31'd0, cpu_done}, 32'd0);
    check("rstmid_hit_cnt",  {16'd0, hit_cnt},  32'd0);
    check("rstmid_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    acks_allowed = -1;
    $display("[TB] RST during fill of 2469 after %0d cycles", n);

    // Line was never validated: full miss again
    exp_mem(1'b1, 16'h2468, 8'h00);
    exp_mem(1'b1, 16'h2469, 8'h00);
    exp_da(1'b0, 4'h4, 1'b0, 8'hD0);
    exp_da(1'b0, 4'h4, 1'b1, 8'hD1);
    do_req(1'b1, 16'h2468, 8'h00, 1'b0, 8'hD0, 0);
    check("post_rst_miss_cnt", {16'd0, miss_cnt}, 32'd1);
    check("post_rst_hit_cnt",  {16'd0, hit_cnt},  32'd0);

    repeat (4) @(negedge clk);
    check("cpu_q_left", cpu_q.size(), 32'd0);
    check("mem_q_left", mem_q.size(), 32'd0);
    check("da_q_left",  da_q.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the 2-way set-associative byte cache: 16 sets x 2 ways, 2-byte lines, 16-bit address, 8-bit data.
- Owns the tag, valid and LRU state. Drives the external data array, which is combinational-read with a synchronous byte write.
- Services one CPU request at a time. Handles read-miss line fills from main memory. Writes are write-through, no-write-allocate.
- Sits between the CPU bus interface and the memory bus.

Parameters:
- AW, 16, address width
- DW, 8, data width
- IW, 4, set index width (index = addr[IW:1], word = addr[0], tag = addr[AW-1:IW+1], 11 bits at defaults)
- CW, 16, width of the hit/miss statistics counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request; held high until cpu_done
- cpu_rw_  in  1  1 = read, 0 = write
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data; valid while cpu_done = 1
- cpu_done  out  1  one-cycle completion pulse
- cpu_hit  out  1  hit flag for the completing access; valid while cpu_done = 1
- mem_req  out  1  memory request; held until mem_ack
- mem_rw_  out  1  1 = read, 0 = write
- mem_addr  out  AW  memory byte address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle memory completion
- da_way  out  1  data-array way select
- da_index  out  IW  data-array set select
- da_word  out  1  data-array byte select
- da_wdata  out  DW  data-array write byte
- da_we  out  1  data-array write enable, one-cycle pulse
- da_rdata  in  DW  data-array read byte (combinational from way/index/word)
- hit_cnt  out  CW  saturating count of hits
- miss_cnt  out  CW  saturating count of misses

Behaviour:
- Reset (rst = 1 at an edge, any state):
  - state = IDLE; all valid bits and all LRU bits cleared.
  - All outputs 0: cpu_done, mem_req, da_we, cpu_rdata, cpu_hit, hit_cnt, miss_cnt.
  - Tags are not cleared.
  - Reset mid-fill or mid-write: mem_req deasserts on the next cycle and the line is not validated.
- States: IDLE, LOOKUP, FILL0, FILL1, MEMWR, DONE.
- IDLE:
  - On cpu_req = 1, latch addr, rw_ and wdata, then go to LOOKUP.
  - cpu_req is not sampled in any other state.
- LOOKUP (one cycle):
  - hit_w = valid[idx][w] & (tag[idx][w] == tag). Way 0 and way 1 both hitting cannot occur.
  - Read hit: cpu_rdata <= da_rdata (da_way = hit way, da_word = word); cpu_hit <= 1; lru[idx] <= ~hit way; hit_cnt++; go to DONE. Latency is request-sample edge + 2 edges to cpu_done.
  - Read miss: victim = way 0 if invalid, else way 1 if invalid, else lru[idx]. miss_cnt++; go to FILL0.
  - Write hit: da_we = 1 to the hit way/word with wdata; lru[idx] <= ~hit way; hit_cnt++; go to MEMWR.
  - Write miss: no array write and no allocation; miss_cnt++; go to MEMWR.
- FILL0 / FILL1:
  - mem_req = 1, mem_rw_ = 1, mem_addr = {tag, idx, 1'b0} in FILL0 and {tag, idx, 1'b1} in FILL1.
  - On mem_ack: da_we = 1 writes mem_rdata to the victim way at word 0 (FILL0) or word 1 (FILL1).
  - If the written byte is the requested word, capture it into cpu_rdata.
  - mem_req drops in the cycle after ack.
  - On the FILL1 ack: tag[idx][victim] <= tag, valid <= 1, lru[idx] <= ~victim, cpu_hit <= 0, go to DONE.
- MEMWR:
  - mem_req = 1, mem_rw_ = 0, mem_addr = latched addr, mem_wdata = latched wdata.
  - On mem_ack: cpu_hit <= hit result from LOOKUP; go to DONE.
- DONE: cpu_done = 1 for exactly one cycle, then go to IDLE. A new request can be sampled in the following IDLE cycle.
- Counters saturate at all-ones. A hit and a miss are never counted in the same cycle.
- mem_ack outside FILL0, FILL1 or MEMWR is ignored.
- cpu_rdata after a write completion is don't-care. The bench must not check it.

Test Plan:
- Reset, then read 0x1234 with memory returning 0xA0 / 0xA1 for 0x1234 / 0x1235 -> two mem reads (0x1234, then 0x1235), cpu_rdata = 0xA0, cpu_hit = 0, miss_cnt = 1.
- Read 0x1235 after the previous test -> no mem_req, cpu_done exactly 2 cycles after request sample, cpu_rdata = 0xA1, cpu_hit = 1, hit_cnt = 1.
- Fill 0x1234 (way 0) and 0x3234 (same set, way 1), re-read 0x1234, then read 0x5234 -> victim is way 1; a subsequent read of 0x3234 misses and a read of 0x1234 hits.
- Write 0x55 to 0x1235 on a cached line -> da_we pulse to the hit way at word 1, then mem write 0x1235 / 0x55; a read of 0x1235 returns 0x55 with a hit.
- Write 0x77 to uncached 0x7000 -> one mem write, no da_we, cpu_hit = 0; a read of 0x7000 then misses.
- Assert rst while mem_req is high in FILL1 -> mem_req is 0 the next cycle; re-reading the same address misses and all counters read 0.
